// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm path controller.
//   alarm_state_t : FSM state encodings (ST_IDLE/ST_RING/ST_SNOOZE/ST_DONE)
//   MS_PER_SEC    : clk_1k cycles per second
//   MS_W          : width of the millisecond counter
//   sec_width()   : width of the shared second counter for a given maximum count
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_DONE   = 2'd3
    } alarm_state_t;

    localparam int MS_PER_SEC = 1000;
    localparam int MS_W       = 10;

    // Second counter never narrower than 12 bits; grows if a longer
    // ring or snooze interval is configured.
    function automatic int sec_width(input int max_cnt);
        int w;
        w = $clog2(max_cnt);
        return (w < 12) ? 12 : w;
    endfunction

endpackage

// File: rtl/alarm_ctrl_beep_gen.sv
// beep_gen: beep cadence generator shared by alarm ring and hourly chime.
//   clk_1k   in  : 1 kHz clock
//   cr       in  : asynchronous active-low reset
//   tick_1hz in  : one-cycle pulse per second, restarts the ms counter
//   en       in  : cadence enable (ring or chime active)
//   tone     out : buzzer drive, 500 Hz square during the first BEEP_MS ms of each second
module beep_gen
    import alarm_pkg::*;
#(
    parameter int BEEP_MS = 500
) (
    input  logic clk_1k,
    input  logic cr,
    input  logic tick_1hz,
    input  logic en,
    output logic tone
);

    localparam logic [MS_W-1:0] MS_MAX   = MS_W'(MS_PER_SEC - 1);
    localparam logic [MS_W-1:0] BEEP_LIM = MS_W'(BEEP_MS);

    logic [MS_W-1:0] ms_cnt;

    always_ff @(posedge clk_1k or negedge cr) begin
        if (!cr) begin
            ms_cnt <= '0;
            tone   <= 1'b0;
        end else begin
            // saturate so a missing tick leaves the tone off
            if (tick_1hz)
                ms_cnt <= '0;
            else if (ms_cnt != MS_MAX)
                ms_cnt <= ms_cnt + 1'b1;

            if (en && (ms_cnt < BEEP_LIM))
                tone <= ~tone;
            else
                tone <= 1'b0;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm compare + ring/snooze/stop sequencer with buzzer cadence.
//   clk_1k                     in  : 1 kHz clock
//   cr                         in  : asynchronous active-low reset
//   tick_1hz                   in  : one-cycle pulse per second
//   alarm_en                   in  : alarm enable switch (level)
//   stop_key, snooze_key       in  : debounced key levels, acted on at rising edge
//   bcd_tmu/tmt/thu/tht        in  : current time digits (min units, min tens, hr units, hr tens)
//   bcd_smu/smt/shu/sht        in  : alarm set time digits, same order
//   ring                       out : high while in RING
//   tone                       out : buzzer drive
//   state_o                    out : current state encoding
//   snooze_cnt                 out : snoozes used in the current alarm event
// Optional macro HOURLY_CHIME_EN: 2 s beep at the top of each hour while IDLE.
//
// State table:
//   ST_IDLE   | waiting for a new match of time against set time
//   ST_RING   | buzzer cadence active, keys accepted, times out after RING_SEC
//   ST_SNOOZE | silent, counting SNOOZE_MIN minutes before ringing again
//   ST_DONE   | event finished, waits for the set minute to pass
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3,
    parameter int BEEP_MS    = 500
) (
    input  logic       clk_1k,
    input  logic       cr,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic       stop_key,
    input  logic       snooze_key,
    input  logic [3:0] bcd_tmu,
    input  logic [3:0] bcd_tmt,
    input  logic [3:0] bcd_thu,
    input  logic [3:0] bcd_tht,
    input  logic [3:0] bcd_smu,
    input  logic [3:0] bcd_smt,
    input  logic [3:0] bcd_shu,
    input  logic [3:0] bcd_sht,
    output logic       ring,
    output logic       tone,
    output logic [1:0] state_o,
    output logic [1:0] snooze_cnt
);

    localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
    localparam int SEC_W = sec_width((RING_SEC > SNOOZE_TICKS) ? RING_SEC : SNOOZE_TICKS);
    localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_SEC - 1);
    localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_TICKS - 1);
    localparam logic [1:0]       MAX_SNZ     = 2'(MAX_SNOOZE);

    alarm_state_t     state, state_nx;
    logic [SEC_W-1:0] sec_cnt, sec_nx;
    logic [1:0]       snz_nx;
    logic             equ, equ_d, equ_rise;
    logic             stop_d, snooze_d, stop_ev, snooze_ev;
    logic             armed;
    logic             beep_en;

    assign equ = (bcd_tmu == bcd_smu) && (bcd_tmt == bcd_smt) &&
                 (bcd_thu == bcd_shu) && (bcd_tht == bcd_sht);

    // armed stays low for the first cycle after reset so a match that is
    // already present at reset release is only sampled, never treated as an edge
    assign equ_rise  = equ & ~equ_d & armed;
    assign stop_ev   = stop_key & ~stop_d;
    assign snooze_ev = snooze_key & ~snooze_d;

    always_ff @(posedge clk_1k or negedge cr) begin
        if (!cr) begin
            state      <= ST_IDLE;
            sec_cnt    <= '0;
            snooze_cnt <= 2'd0;
            ring       <= 1'b0;
            equ_d      <= 1'b0;
            stop_d     <= 1'b1;
            snooze_d   <= 1'b1;
            armed      <= 1'b0;
        end else begin
            state      <= state_nx;
            sec_cnt    <= sec_nx;
            snooze_cnt <= snz_nx;
            ring       <= (state_nx == ST_RING);
            equ_d      <= equ;
            stop_d     <= stop_key;
            snooze_d   <= snooze_key;
            armed      <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        sec_nx   = sec_cnt;
        snz_nx   = snooze_cnt;
        case (state)
            ST_IDLE: begin
                if (equ_rise && alarm_en) begin
                    state_nx = ST_RING;
                    sec_nx   = '0;
                    snz_nx   = 2'd0;
                end
            end
            ST_RING: begin
                if (!alarm_en || stop_ev) begin
                    state_nx = ST_DONE;
                end else if (snooze_ev) begin
                    if (snooze_cnt < MAX_SNZ) begin
                        state_nx = ST_SNOOZE;
                        snz_nx   = snooze_cnt + 2'd1;
                        sec_nx   = '0;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end else if (tick_1hz) begin
                    if (sec_cnt == RING_LAST)
                        state_nx = ST_DONE;
                    else
                        sec_nx = sec_cnt + 1'b1;
                end
            end
            ST_SNOOZE: begin
                if (!alarm_en || stop_ev) begin
                    state_nx = ST_DONE;
                end else if (tick_1hz) begin
                    if (sec_cnt == SNOOZE_LAST) begin
                        state_nx = ST_RING;
                        sec_nx   = '0;
                    end else begin
                        sec_nx = sec_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!equ)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign state_o = state;

`ifdef HOURLY_CHIME_EN
    logic       top_hr, top_hr_d, chime_on;
    logic       chime_ticks;

    assign top_hr = (bcd_tmu == 4'd0) && (bcd_tmt == 4'd0);

    // chime lasts two ticks; leaving IDLE (alarm wins) cancels it
    always_ff @(posedge clk_1k or negedge cr) begin
        if (!cr) begin
            top_hr_d    <= 1'b0;
            chime_on    <= 1'b0;
            chime_ticks <= 1'b0;
        end else begin
            top_hr_d <= top_hr;
            if ((state != ST_IDLE) || (state_nx != ST_IDLE)) begin
                chime_on    <= 1'b0;
                chime_ticks <= 1'b0;
            end else if (armed && top_hr && !top_hr_d) begin
                chime_on    <= 1'b1;
                chime_ticks <= 1'b0;
            end else if (chime_on && tick_1hz) begin
                if (chime_ticks)
                    chime_on <= 1'b0;
                chime_ticks <= ~chime_ticks;
            end
        end
    end

    assign beep_en = ring | chime_on;
`else
    assign beep_en = ring;
`endif

    beep_gen #(
        .BEEP_MS (BEEP_MS)
    ) u_beep (
        .clk_1k   (clk_1k),
        .cr       (cr),
        .tick_1hz (tick_1hz),
        .en       (beep_en),
        .tone     (tone)
    );

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed self-checking bench for alarm_ctrl.
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_alarm_ctrl;

    logic       clk_1k = 1'b0;
    logic       cr = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       alarm_en = 1'b0;
    logic       stop_key = 1'b0;
    logic       snooze_key = 1'b0;
    logic [3:0] bcd_tmu = 4'd0, bcd_tmt = 4'd0, bcd_thu = 4'd0, bcd_tht = 4'd0;
    logic [3:0] bcd_smu = 4'd0, bcd_smt = 4'd0, bcd_shu = 4'd0, bcd_sht = 4'd0;
    logic       ring, tone;
    logic [1:0] state_o, snooze_cnt;

    int checks = 0;
    int errors = 0;
    int cnt;

`ifdef HOURLY_CHIME_EN
    localparam int CHIME_TOGGLES = 100;
`else
    localparam int CHIME_TOGGLES = 0;
`endif

    alarm_ctrl dut (
        .clk_1k     (clk_1k),
        .cr         (cr),
        .tick_1hz   (tick_1hz),
        .alarm_en   (alarm_en),
        .stop_key   (stop_key),
        .snooze_key (snooze_key),
        .bcd_tmu    (bcd_tmu),
        .bcd_tmt    (bcd_tmt),
        .bcd_thu    (bcd_thu),
        .bcd_tht    (bcd_tht),
        .bcd_smu    (bcd_smu),
        .bcd_smt    (bcd_smt),
        .bcd_shu    (bcd_shu),
        .bcd_sht    (bcd_sht),
        .ring       (ring),
        .tone       (tone),
        .state_o    (state_o),
        .snooze_cnt (snooze_cnt)
    );

    always #5 clk_1k = ~clk_1k;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_1k);
    endtask

    task automatic set_time(input int h, input int m);
        bcd_tht = 4'(h / 10); bcd_thu = 4'(h % 10);
        bcd_tmt = 4'(m / 10); bcd_tmu = 4'(m % 10);
    endtask

    task automatic set_alarm(input int h, input int m);
        bcd_sht = 4'(h / 10); bcd_shu = 4'(h % 10);
        bcd_smt = 4'(m / 10); bcd_smu = 4'(m % 10);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            step(1);
            tick_1hz = 1'b0;
            step(1);
        end
    endtask

    task automatic keys(input logic s, input logic z);
        stop_key = s; snooze_key = z;
        step(1);
        stop_key = 1'b0; snooze_key = 1'b0;
        step(1);
    endtask

    // count tone changes over n samples after skipping some cycles
    task automatic toggles(input int skip, input int n, output int c);
        logic prev;
        step(skip);
        prev = tone;
        c = 0;
        repeat (n) begin
            step(1);
            if (tone !== prev) c++;
            prev = tone;
        end
    endtask

    task automatic highs(input int skip, input int n, output int c);
        step(skip);
        c = 0;
        repeat (n) begin
            step(1);
            if (tone !== 1'b0) c++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        set_alarm(7, 30);
        set_time(7, 29);
        alarm_en = 1'b1;
        step(2);
        chk("rst_state", state_o, 0);
        chk("rst_ring", ring, 0);
        chk("rst_tone", tone, 0);
        chk("rst_snz", snooze_cnt, 0);
        cr = 1'b1;
        step(3);
        chk("idle_before_match", state_o, 0);

        // match and ring cadence
        set_time(7, 30);
        chk("ring_not_yet", ring, 0);
        step(1);
        chk("ring_rise", ring, 1);
        chk("state_ring", state_o, 1);
        tick(1);
        toggles(8, 100, cnt);
        chk("tone_on_window", cnt, 100);
        highs(600, 300, cnt);
        chk("tone_off_window", cnt, 0);

        // timeout: one tick already counted, 58 more keep ringing, 60th stops
        tick(58);
        chk("ring_at_59", state_o, 1);
        tick(1);
        chk("done_at_60", state_o, 3);
        chk("ring_off_60", ring, 0);
        step(5);
        chk("no_rering", state_o, 3);
        set_time(7, 31);
        step(1);
        chk("done_to_idle", state_o, 0);

        // snooze cycles
        set_time(7, 30);
        step(1);
        chk("ring_again", state_o, 1);
        for (int i = 1; i <= 3; i++) begin
            keys(1'b0, 1'b1);
            chk("snooze_state", state_o, 2);
            chk("snooze_cnt", snooze_cnt, 32'(i));
            chk("snooze_silent", ring, 0);
            tick(299);
            chk("snooze_299", state_o, 2);
            tick(1);
            chk("snooze_back_ring", state_o, 1);
            chk("snooze_cnt_held", snooze_cnt, 32'(i));
        end
        keys(1'b0, 1'b1);
        chk("fourth_snooze_done", state_o, 3);
        chk("fourth_snooze_cnt", snooze_cnt, 3);

        // stop and snooze together
        set_time(7, 31); step(1);
        set_time(7, 30); step(1);
        chk("ring_fresh", state_o, 1);
        chk("snz_cleared", snooze_cnt, 0);
        keys(1'b1, 1'b1);
        chk("both_keys_done", state_o, 3);
        chk("both_keys_snz", snooze_cnt, 0);

        // alarm_en drop in snooze
        set_time(7, 31); step(1);
        set_time(7, 30); step(1);
        keys(1'b0, 1'b1);
        chk("snooze_pre_drop", state_o, 2);
        alarm_en = 1'b0;
        step(1);
        chk("en_drop_done", state_o, 3);
        alarm_en = 1'b1;

        // asynchronous reset mid-ring
        set_time(7, 31); step(1);
        set_time(7, 30); step(1);
        tick(1);
        toggles(4, 20, cnt);
        chk("tone_before_rst", cnt, 20);
        #2 cr = 1'b0;
        #1;
        chk("async_ring", ring, 0);
        chk("async_tone", tone, 0);
        chk("async_state", state_o, 0);
        @(negedge clk_1k);
        cr = 1'b1;
        step(5);
        chk("no_ring_after_rst", state_o, 0);
        set_time(7, 31); step(1);
        set_time(7, 30); step(1);
        chk("ring_later_match", ring, 1);
        keys(1'b1, 1'b0);
        chk("stop_done", state_o, 3);

        // hourly chime (tone only when the chime is built in)
        set_alarm(12, 0);
        set_time(8, 59);
        step(1);
        chk("chime_pre_idle", state_o, 0);
        set_time(9, 0);
        step(1);
        tick(1);
        toggles(8, 100, cnt);
        chk("chime_tone", cnt, CHIME_TOGGLES);
        chk("chime_ring", ring, 0);
        chk("chime_state", state_o, 0);
        step(880);
        tick(1);
        step(880);
        tick(1);
        toggles(8, 100, cnt);
        chk("chime_ended", cnt, 0);

        // alarm at the hour takes priority
        set_time(8, 59);
        set_alarm(9, 0);
        step(1);
        set_time(9, 0);
        step(1);
        chk("hour_alarm_ring", ring, 1);
        chk("hour_alarm_state", state_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
